dpram_pattern_checker: RTL and testbench
========================================

# dpram_pattern_checker

Self-checking traffic stage that sits directly upstream of the one-cycle true dual-port block RAM in the dual-port RAM unit test. It drives both RAM ports with an address-derived pattern, writing a full pass and reading it back, then compares every returned word and its valid strobe. It reports busy/done status, a saturating error count and the first failing address to the test harness.

## Interface
- DATA_WIDTH, 32, RAM word width; must match the RAM instance
- ADDR_WIDTH, 10, RAM address width; a pass covers 2**ADDR_WIDTH words
- ERR_WIDTH, 16, width of the saturating error counter
- CLK  in  1  sole clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  begin a test run; sampled only in IDLE
- SEED  in  DATA_WIDTH  pattern seed; latched on the accepted START
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  single-cycle pulse when a run completes
- ERR_COUNT  out  ERR_WIDTH  mismatches in the last/current run; saturates at all-ones
- FIRST_ERR_ADDR  out  ADDR_WIDTH  address of the first mismatch; valid when ERR_COUNT != 0
- ADDR_A, ADDR_B  out  ADDR_WIDTH  RAM port addresses
- DI_A, DI_B  out  DATA_WIDTH  RAM write data
- WE_A, WE_B, EN_A, EN_B  out  1  RAM write enables and port enables
- DO_A, DO_B  in  DATA_WIDTH  RAM read data, one cycle after the read
- DO_VALID_A, DO_VALID_B  in  1  RAM read-valid strobes, one cycle after the read

## Operation
- Pattern: P(a) = zero-extend-or-truncate(a, DATA_WIDTH) XOR seed_q.
- States: IDLE -> WRITE -> READ -> DRAIN -> FIN -> IDLE.
- IDLE: all RAM enables low. On START=1, latch SEED, clear ERR_COUNT and FIRST_ERR_ADDR, and go to WRITE.
- WRITE: EN_A=WE_A=1, ADDR_A=cnt, DI_A=P(cnt), with cnt ascending from 0. After cnt = 2**ADDR_WIDTH-1, reset cnt to 0 and go to READ. Port B stays idle.
- READ: EN_B=1, WE_B=0, ADDR_B=cnt, with cnt ascending from 0. Register the issued address in exp_addr and set exp_v=1. The last address goes to DRAIN.
- Check: in every cycle where exp_v was set in the previous cycle, compare the two conditions below. A mismatch on either counts one error. The FIRST_ERR_ADDR write happens only when ERR_COUNT was 0.
  - DO_VALID_B must be 1.
  - DO_B must equal P(exp_addr).
- Unexpected read-valid: DO_VALID_B or DO_VALID_A high with no read outstanding counts as an error. FIRST_ERR_ADDR is not updated for this case.
- DRAIN: no RAM access; perform the final compare.
- FIN: DONE=1 for one cycle, BUSY=0, then return to IDLE. ERR_COUNT and FIRST_ERR_ADDR hold until the next accepted START.
- ERR_COUNT saturates at 2**ERR_WIDTH-1; it never wraps.
- START while BUSY is ignored.
- Idle DI and ADDR outputs are driven to 0.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, seed_q 0, exp_v 0. Reset takes effect immediately and asynchronously, including mid-run; the RAM contents are left as they are.
- If START is sampled at edge k, then:
  - the first write is driven in cycle k+1;
  - the first read is driven at k+1+N, where N = 2**ADDR_WIDTH;
  - DONE is high in cycle k+2N+2.
- Run length is fixed at 2N+2 cycles after the sample edge; there is no back-pressure.
- Read latency is exactly one cycle. Data or valid arriving later counts as an error.
- cnt wraps from N-1 to 0 only on the state transition. No address is repeated or skipped.

## Configuration
- DPRAM_CHECKER_CROSS_EN: when defined, a second write/read pair is inserted between DRAIN and FIN:
  - WRITE_B: port B writes ~P(a).
  - READ_A: port A reads, checked against DO_A and DO_VALID_A.
  - DRAIN2: final compare for the port-A reads.
  - Run length becomes 4N+3 cycles, with DONE in cycle k+4N+3.
- Undefined: only the A-write/B-read pass exists; DO_A and DO_VALID_A are only checked for spurious valids.

## Test plan
- Clean run, DATA_WIDTH=8, ADDR_WIDTH=4, SEED=0xA5: DI_A=0xA6 at address 3 and DONE in cycle k+34, with ERR_COUNT=0 and BUSY high for cycles k+1..k+33.
- Corrupted data: the RAM model flips bit 0 of address 5 on readback -> ERR_COUNT=1, FIRST_ERR_ADDR=5.
- Missing valid: the RAM model suppresses DO_VALID_B for the address-9 read -> ERR_COUNT=1, FIRST_ERR_ADDR=9.
- Saturation, ERR_WIDTH=2: the RAM model returns 0 for every read with SEED=0xFF -> ERR_COUNT=3 and FIRST_ERR_ADDR=0.
- Reset mid-run: RST_N low during the WRITE cycle for address 7 -> all outputs 0 at once and state IDLE. A new START gives a clean run with ERR_COUNT=0.
- START held high throughout the run: no restart. Exactly one DONE per run, and a new run starts the cycle after FIN.
- With DPRAM_CHECKER_CROSS_EN and ADDR_WIDTH=4: DONE in cycle k+67, ERR_COUNT=0, and DI_B=0x59 at address 3 for SEED=0xA5.

Source files
------------

// File: rtl/dpram_pattern_checker.sv
// Address-pattern write/readback checker driving a one-cycle true dual-port RAM.
// Optional DPRAM_CHECKER_CROSS_EN adds a port-B write / port-A read second pass.
module dpram_pattern_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] SEED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ERR_WIDTH-1:0]  ERR_COUNT,
  output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
  output logic [ADDR_WIDTH-1:0] ADDR_A,
  output logic [ADDR_WIDTH-1:0] ADDR_B,
  output logic [DATA_WIDTH-1:0] DI_A,
  output logic [DATA_WIDTH-1:0] DI_B,
  output logic                  WE_A,
  output logic                  WE_B,
  output logic                  EN_A,
  output logic                  EN_B,
  input  logic [DATA_WIDTH-1:0] DO_A,
  input  logic [DATA_WIDTH-1:0] DO_B,
  input  logic                  DO_VALID_A,
  input  logic                  DO_VALID_B
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_WRITE_B = 3'd4,
    ST_READ_A  = 3'd5,
    ST_DRAIN2  = 3'd6,
    ST_FIN     = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};

  function automatic logic [DATA_WIDTH-1:0] pattern_f(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    return ext[DATA_WIDTH-1:0] ^ s;
  endfunction

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [DATA_WIDTH-1:0]   seed_r;
  logic                    exp_v_a_r;
  logic                    exp_v_b_r;
  logic [ADDR_WIDTH-1:0]   exp_addr_r;
  logic                    busy_r;
  logic                    done_r;
  logic [ERR_WIDTH-1:0]    err_cnt_r;
  logic [ADDR_WIDTH-1:0]   first_err_r;
  logic [ADDR_WIDTH-1:0]   addr_a_r;
  logic [ADDR_WIDTH-1:0]   addr_b_r;
  logic [DATA_WIDTH-1:0]   di_a_r;
  logic [DATA_WIDTH-1:0]   di_b_r;
  logic                    we_a_r;
  logic                    we_b_r;
  logic                    en_a_r;
  logic                    en_b_r;

  logic [ADDR_WIDTH-1:0]   cnt_inc_s;
  logic [DATA_WIDTH-1:0]   exp_pat_s;
  logic                    chk_a_err_s;
  logic                    chk_b_err_s;
  logic                    spur_a_s;
  logic                    spur_b_s;
  logic [1:0]              err_inc_s;
  logic [ERR_WIDTH:0]      err_sum_s;
  logic [ERR_WIDTH-1:0]    err_next_s;

`ifndef DPRAM_CHECKER_CROSS_EN
  // Port-A read data has nothing to be compared against in the single-pass build.
  logic unused_do_a_s;
  assign unused_do_a_s = ^DO_A;
`endif

  // Readback comparison and saturating error-count arithmetic.
  always_comb begin
    cnt_inc_s   = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    exp_pat_s   = pattern_f(exp_addr_r, seed_r);
    chk_b_err_s = exp_v_b_r && (!DO_VALID_B || (DO_B != exp_pat_s));
    spur_b_s    = DO_VALID_B && !exp_v_b_r;
    spur_a_s    = DO_VALID_A && !exp_v_a_r;
`ifdef DPRAM_CHECKER_CROSS_EN
    chk_a_err_s = exp_v_a_r && (!DO_VALID_A || (DO_A != ~exp_pat_s));
`else
    chk_a_err_s = 1'b0;
`endif
    err_inc_s = {1'b0, (chk_a_err_s | spur_a_s)} + {1'b0, (chk_b_err_s | spur_b_s)};
    err_sum_s = {1'b0, err_cnt_r} + {{(ERR_WIDTH-1){1'b0}}, err_inc_s};
    if (err_sum_s[ERR_WIDTH]) begin
      err_next_s = {ERR_WIDTH{1'b1}};
    end else begin
      err_next_s = err_sum_s[ERR_WIDTH-1:0];
    end
  end

  // Sequencer: state, counter, expectation pipeline, status and RAM port registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      seed_r      <= {DATA_WIDTH{1'b0}};
      exp_v_a_r   <= 1'b0;
      exp_v_b_r   <= 1'b0;
      exp_addr_r  <= CNT_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_cnt_r   <= {ERR_WIDTH{1'b0}};
      first_err_r <= CNT_ZERO;
      addr_a_r    <= CNT_ZERO;
      addr_b_r    <= CNT_ZERO;
      di_a_r      <= {DATA_WIDTH{1'b0}};
      di_b_r      <= {DATA_WIDTH{1'b0}};
      we_a_r      <= 1'b0;
      we_b_r      <= 1'b0;
      en_a_r      <= 1'b0;
      en_b_r      <= 1'b0;
    end else begin
      // Ports idle unless the next state drives them.
      done_r   <= 1'b0;
      en_a_r   <= 1'b0;
      we_a_r   <= 1'b0;
      en_b_r   <= 1'b0;
      we_b_r   <= 1'b0;
      addr_a_r <= CNT_ZERO;
      addr_b_r <= CNT_ZERO;
      di_a_r   <= {DATA_WIDTH{1'b0}};
      di_b_r   <= {DATA_WIDTH{1'b0}};

      // A read driven this cycle returns data on the next edge.
      exp_v_a_r  <= en_a_r & ~we_a_r;
      exp_v_b_r  <= en_b_r & ~we_b_r;
      exp_addr_r <= en_b_r ? addr_b_r : addr_a_r;

      if (busy_r) begin
        err_cnt_r <= err_next_s;
        if ((err_cnt_r == {ERR_WIDTH{1'b0}}) && (chk_a_err_s || chk_b_err_s)) begin
          first_err_r <= exp_addr_r;
        end else begin
          first_err_r <= first_err_r;
        end
      end else begin
        err_cnt_r <= err_cnt_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (START) begin
            state_r     <= ST_WRITE;
            busy_r      <= 1'b1;
            seed_r      <= SEED;
            err_cnt_r   <= {ERR_WIDTH{1'b0}};
            first_err_r <= CNT_ZERO;
            cnt_r       <= CNT_ZERO;
            en_a_r      <= 1'b1;
            we_a_r      <= 1'b1;
            di_a_r      <= pattern_f(CNT_ZERO, SEED);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_READ;
            cnt_r   <= CNT_ZERO;
            en_b_r  <= 1'b1;
          end else begin
            cnt_r    <= cnt_inc_s;
            en_a_r   <= 1'b1;
            we_a_r   <= 1'b1;
            addr_a_r <= cnt_inc_s;
            di_a_r   <= pattern_f(cnt_inc_s, seed_r);
          end
        end
        ST_READ: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DRAIN;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r    <= cnt_inc_s;
            en_b_r   <= 1'b1;
            addr_b_r <= cnt_inc_s;
          end
        end
        ST_DRAIN: begin
`ifdef DPRAM_CHECKER_CROSS_EN
          state_r <= ST_WRITE_B;
          cnt_r   <= CNT_ZERO;
          en_b_r  <= 1'b1;
          we_b_r  <= 1'b1;
          di_b_r  <= ~pattern_f(CNT_ZERO, seed_r);
`else
          state_r <= ST_FIN;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
`endif
        end
`ifdef DPRAM_CHECKER_CROSS_EN
        ST_WRITE_B: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_READ_A;
            cnt_r   <= CNT_ZERO;
            en_a_r  <= 1'b1;
          end else begin
            cnt_r    <= cnt_inc_s;
            en_b_r   <= 1'b1;
            we_b_r   <= 1'b1;
            addr_b_r <= cnt_inc_s;
            di_b_r   <= ~pattern_f(cnt_inc_s, seed_r);
          end
        end
        ST_READ_A: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DRAIN2;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r    <= cnt_inc_s;
            en_a_r   <= 1'b1;
            addr_a_r <= cnt_inc_s;
          end
        end
        ST_DRAIN2: begin
          state_r <= ST_FIN;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
`endif
        ST_FIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY           = busy_r;
  assign DONE           = done_r;
  assign ERR_COUNT      = err_cnt_r;
  assign FIRST_ERR_ADDR = first_err_r;
  assign ADDR_A         = addr_a_r;
  assign ADDR_B         = addr_b_r;
  assign DI_A           = di_a_r;
  assign DI_B           = di_b_r;
  assign WE_A           = we_a_r;
  assign WE_B           = we_b_r;
  assign EN_A           = en_a_r;
  assign EN_B           = en_b_r;

endmodule

// File: tb/tb_dpram_pattern_checker.sv
// Directed bench for dpram_pattern_checker with a behavioural one-cycle dual-port RAM
// that can corrupt data, drop valids, return zeros or raise a stray port-A valid.
module tb_dpram_pattern_checker;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int EW = 2;
  localparam int N  = 16;
`ifdef DPRAM_CHECKER_CROSS_EN
  localparam int RUN_LEN = 4*N + 3;
`else
  localparam int RUN_LEN = 2*N + 2;
`endif

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [DW-1:0] SEED;
  logic          BUSY;
  logic          DONE;
  logic [EW-1:0] ERR_COUNT;
  logic [AW-1:0] FIRST_ERR_ADDR;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic [DW-1:0] DI_A, DI_B;
  logic          WE_A, WE_B, EN_A, EN_B;
  logic [DW-1:0] DO_A, DO_B;
  logic          DO_VALID_A, DO_VALID_B;

  int n_checks = 0;
  int n_errors = 0;

  int            corrupt_addr = -1;
  int            drop_addr    = -1;
  bit            zero_rd      = 1'b0;
  bit            spur_a       = 1'b0;
  logic [DW-1:0] mem [0:N-1];
  logic [DW-1:0] ram_do_a, ram_do_b;
  logic          ram_vld_a = 1'b0;
  logic          ram_vld_b = 1'b0;
  logic [DW-1:0] di_a3, di_b3;

  dpram_pattern_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SEED(SEED),
    .BUSY(BUSY), .DONE(DONE), .ERR_COUNT(ERR_COUNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DI_A(DI_A), .DI_B(DI_B),
    .WE_A(WE_A), .WE_B(WE_B), .EN_A(EN_A), .EN_B(EN_B),
    .DO_A(DO_A), .DO_B(DO_B), .DO_VALID_A(DO_VALID_A), .DO_VALID_B(DO_VALID_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One-cycle RAM with fault hooks on the read paths.
  always @(posedge CLK) begin
    if (EN_A) begin
      if (WE_A) mem[ADDR_A] <= DI_A;
      else      ram_do_a <= zero_rd ? 8'h00 : mem[ADDR_A];
    end
    if (EN_B) begin
      if (WE_B) mem[ADDR_B] <= DI_B;
      else      ram_do_b <= zero_rd ? 8'h00 :
                            (mem[ADDR_B] ^ ((int'(ADDR_B) == corrupt_addr) ? 8'h01 : 8'h00));
    end
    ram_vld_a <= EN_A && !WE_A;
    ram_vld_b <= EN_B && !WE_B && (int'(ADDR_B) != drop_addr);
  end

  assign DO_A       = ram_do_a;
  assign DO_B       = ram_do_b;
  assign DO_VALID_A = ram_vld_a | spur_a;
  assign DO_VALID_B = ram_vld_b;

  always @(negedge CLK) begin
    if (EN_A && WE_A && ADDR_A == 4'd3) di_a3 = DI_A;
    if (EN_B && WE_B && ADDR_B == 4'd3) di_b3 = DI_B;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a run at the next edge k; returns m such that DONE is seen in cycle k+m.
  task automatic do_run(input logic [DW-1:0] seed, input int spur_m,
                        output int done_m, output int busy_err);
    done_m   = -1;
    busy_err = 0;
    @(negedge CLK);
    SEED  = seed;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    for (int m = 1; m <= RUN_LEN + 20; m++) begin
      spur_a = (m == spur_m);
      if (BUSY !== (m < RUN_LEN)) busy_err++;
      if (DONE === 1'b1) begin
        done_m = m;
        break;
      end
      @(negedge CLK);
    end
    spur_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  done_m, busy_err, d1, d2, dones, found;
    RST_N = 1'b0;
    START = 1'b0;
    SEED  = 8'h00;
    di_a3 = 8'h00;
    di_b3 = 8'h00;
    #22;
    check_eq("rst_ctl", {BUSY, DONE, EN_A, WE_A, EN_B, WE_B}, 32'h0);
    check_eq("rst_err", ERR_COUNT, 32'h0);
    check_eq("rst_first", FIRST_ERR_ADDR, 32'h0);
    check_eq("rst_addr", {ADDR_A, ADDR_B}, 32'h0);
    check_eq("rst_di", {DI_A, DI_B}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Clean run
    do_run(8'hA5, -1, done_m, busy_err);
    check_eq("clean_done_cycle", done_m, RUN_LEN);
    check_eq("clean_busy", busy_err, 32'h0);
    check_eq("clean_err", ERR_COUNT, 32'h0);
    check_eq("clean_di_a3", di_a3, 32'hA6);
`ifdef DPRAM_CHECKER_CROSS_EN
    check_eq("cross_di_b3", di_b3, 32'h59);
`endif
    @(negedge CLK);
    check_eq("done_pulse", {DONE, BUSY, EN_A, EN_B}, 32'h0);

    // Corrupted readback at address 5
    corrupt_addr = 5;
    do_run(8'h3C, -1, done_m, busy_err);
    corrupt_addr = -1;
    check_eq("corrupt_done", done_m, RUN_LEN);
    check_eq("corrupt_err", ERR_COUNT, 32'h1);
    check_eq("corrupt_first", FIRST_ERR_ADDR, 32'h5);

    // Missing valid at address 9
    drop_addr = 9;
    do_run(8'h5A, -1, done_m, busy_err);
    drop_addr = -1;
    check_eq("drop_err", ERR_COUNT, 32'h1);
    check_eq("drop_first", FIRST_ERR_ADDR, 32'h9);

    // Every read returns zero: 2-bit counter saturates
    zero_rd = 1'b1;
    do_run(8'hFF, -1, done_m, busy_err);
    zero_rd = 1'b0;
    check_eq("sat_err", ERR_COUNT, 32'h3);
    check_eq("sat_first", FIRST_ERR_ADDR, 32'h0);
    check_eq("sat_done", done_m, RUN_LEN);

    // Stray port-A valid during the write pass
    do_run(8'h11, 3, done_m, busy_err);
    check_eq("spur_err", ERR_COUNT, 32'h1);
    check_eq("spur_first", FIRST_ERR_ADDR, 32'h0);

    // Asynchronous reset while writing address 7
    @(negedge CLK);
    SEED  = 8'hC3;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    found = 0;
    for (int m = 0; m < 40; m++) begin
      if (EN_A && WE_A && ADDR_A == 4'd7) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    check_eq("mid_found", found, 32'h1);
    check_eq("mid_di_a7", DI_A, 32'hC4);
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {BUSY, DONE, EN_A, WE_A, EN_B, WE_B}, 32'h0);
    check_eq("mid_rst_bus", {ADDR_A, DI_A, ADDR_B, DI_B}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("mid_idle", {BUSY, EN_A, EN_B}, 32'h0);
    do_run(8'hA5, -1, done_m, busy_err);
    check_eq("post_rst_done", done_m, RUN_LEN);
    check_eq("post_rst_err", ERR_COUNT, 32'h0);
    check_eq("post_rst_busy", busy_err, 32'h0);

    // START held high: back-to-back runs, one DONE each
    @(negedge CLK);
    SEED  = 8'h77;
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    d1 = -1;
    d2 = -1;
    for (int m = 1; m <= 2*RUN_LEN + 10; m++) begin
      if (DONE === 1'b1) begin
        if (d1 < 0) d1 = m;
        else begin
          d2 = m;
          START = 1'b0;
          break;
        end
      end
      @(negedge CLK);
    end
    START = 1'b0;
    check_eq("hold_done1", d1, RUN_LEN);
    check_eq("hold_done2", d2, 2*RUN_LEN + 1);
    check_eq("hold_err", ERR_COUNT, 32'h0);
    dones = 0;
    for (int m = 0; m < RUN_LEN + 5; m++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) dones++;
    end
    check_eq("hold_no_third", dones, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
